// File: rtl/rv_bpu_pkg.sv
// rv_bpu_pkg: shared definitions for the branch prediction unit.
//   - BPU_BIMODAL / BPU_GSHARE : PHT indexing mode selectors
//   - ctr_reset_val            : weakly-not-taken counter encoding
//   - ctr_next                 : saturating up/down counter step
//   - bidx_of / tag_of         : BTB index and tag extraction from a PC
// Functions work on 32/64-bit containers; callers cast to their own widths.
package rv_bpu_pkg;

    localparam int BPU_BIMODAL = 0;
    localparam int BPU_GSHARE  = 1;

    // 2^(ctr_w-1)-1: one step below the taken threshold.
    function automatic logic [31:0] ctr_reset_val(input int ctr_w);
        return 32'((64'd1 << (ctr_w - 1)) - 64'd1);
    endfunction

    function automatic logic [31:0] ctr_next(input logic [31:0] ctr,
                                             input logic        taken,
                                             input int          ctr_w);
        logic [31:0] ctr_max;
        ctr_max = 32'((64'd1 << ctr_w) - 64'd1);
        if (taken) begin
            return (ctr == ctr_max) ? ctr : ctr + 32'd1;
        end
        return (ctr == 32'd0) ? ctr : ctr - 32'd1;
    endfunction

    // Instructions are 4-byte aligned, so the index starts at bit 2.
    function automatic logic [31:0] bidx_of(input logic [63:0] pc, input int iw);
        return 32'((pc >> 2) & ((64'd1 << iw) - 64'd1));
    endfunction

    function automatic logic [31:0] tag_of(input logic [63:0] pc, input int iw,
                                           input int tag_w);
        return 32'((pc >> (2 + iw)) & ((64'd1 << tag_w) - 64'd1));
    endfunction

endpackage

// File: rtl/rv_bpu_if.sv
// rv_bpu_if: IF lookup and EX resolution bus between the core and the BPU.
//   master : core side, drives lookup/resolution, receives prediction/flush
//   slave  : BPU side
// Signals: if_valid_i, if_pc_i -> pred_taken_o, pred_target_o, pred_ghr_o;
//          ex_* resolution inputs -> flush_o, redirect_pc_o.
interface rv_bpu_if #(
    parameter int XLEN  = 64,
    parameter int GHR_W = 4
);
    logic             if_valid_i;
    logic [XLEN-1:0]  if_pc_i;
    logic             pred_taken_o;
    logic [XLEN-1:0]  pred_target_o;
    logic [GHR_W-1:0] pred_ghr_o;
    logic             ex_valid_i;
    logic             ex_is_branch_i;
    logic [XLEN-1:0]  ex_pc_i;
    logic             ex_taken_i;
    logic [XLEN-1:0]  ex_target_i;
    logic             ex_pred_taken_i;
    logic [XLEN-1:0]  ex_pred_target_i;
    logic [GHR_W-1:0] ex_ghr_i;
    logic             flush_o;
    logic [XLEN-1:0]  redirect_pc_o;

    modport master (
        output if_valid_i, if_pc_i,
        output ex_valid_i, ex_is_branch_i, ex_pc_i, ex_taken_i, ex_target_i,
        output ex_pred_taken_i, ex_pred_target_i, ex_ghr_i,
        input  pred_taken_o, pred_target_o, pred_ghr_o, flush_o, redirect_pc_o
    );

    modport slave (
        input  if_valid_i, if_pc_i,
        input  ex_valid_i, ex_is_branch_i, ex_pc_i, ex_taken_i, ex_target_i,
        input  ex_pred_taken_i, ex_pred_target_i, ex_ghr_i,
        output pred_taken_o, pred_target_o, pred_ghr_o, flush_o, redirect_pc_o
    );
endinterface

// File: rtl/rv_bpu_btb.sv
// rv_bpu_btb: branch target buffer storage.
//   clk, rst             : clock, synchronous active-high reset (valid bits only)
//   rd_idx -> rd_valid, rd_tag, rd_target : combinational read port
//   wr_en, wr_idx, wr_tag, wr_target      : synchronous write port (sets valid)
module rv_bpu_btb #(
    parameter  int XLEN    = 64,
    parameter  int ENTRIES = 16,
    parameter  int TAG_W   = 8,
    localparam int IW      = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IW-1:0]    rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [XLEN-1:0]  rd_target,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [XLEN-1:0]  wr_target
);
    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [XLEN-1:0]    target_mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tags and targets carry no reset; a write coinciding with reset is dropped
    // so a stale payload never pairs with a later valid bit.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= wr_target;
        end
    end

    assign rd_valid  = valid[rd_idx];
    assign rd_tag    = tag_mem[rd_idx];
    assign rd_target = target_mem[rd_idx];

endmodule

// File: rtl/rv_bpu.sv
// rv_bpu: branch prediction unit (tagged BTB + PHT of saturating counters,
// bimodal or gshare indexing with a speculative GHR).
//   clk, rst : clock, synchronous active-high reset
//   bus      : rv_bpu_if slave -- IF lookup (combinational prediction) and
//              EX resolution (training, GHR repair, flush + redirect PC)
module rv_bpu
    import rv_bpu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int GSHARE  = 0,
    parameter int GHR_W   = 4
) (
    input  logic     clk,
    input  logic     rst,
    rv_bpu_if.slave  bus
);
    localparam int IW = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_reset_val(CTR_W));

    logic [GHR_W-1:0] ghr;
    logic [CTR_W-1:0] pht [ENTRIES];

    logic [IW-1:0]    if_bidx, if_pidx, ex_bidx, ex_pidx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             btb_valid;
    logic [TAG_W-1:0] btb_tag;
    logic [XLEN-1:0]  btb_target;
    logic             hit, pred_taken, train, mispredict;

    // Shift a direction bit into a history; the cast drops the oldest bit,
    // which also covers a one-bit history.
    function automatic logic [GHR_W-1:0] ghr_push(input logic [GHR_W-1:0] h,
                                                  input logic b);
        return GHR_W'({h, b});
    endfunction

    assign if_bidx = IW'(bidx_of(64'(bus.if_pc_i), IW));
    assign if_tag  = TAG_W'(tag_of(64'(bus.if_pc_i), IW, TAG_W));
    assign ex_bidx = IW'(bidx_of(64'(bus.ex_pc_i), IW));
    assign ex_tag  = TAG_W'(tag_of(64'(bus.ex_pc_i), IW, TAG_W));

    // Training uses the history snapshot taken at lookup time, so the same
    // counter that produced the prediction is the one trained.
    assign if_pidx = (GSHARE == BPU_GSHARE) ? (if_bidx ^ IW'(ghr)) : if_bidx;
    assign ex_pidx = (GSHARE == BPU_GSHARE) ? (ex_bidx ^ IW'(bus.ex_ghr_i)) : ex_bidx;

    rv_bpu_btb #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (if_bidx),
        .rd_valid  (btb_valid),
        .rd_tag    (btb_tag),
        .rd_target (btb_target),
        .wr_en     (train && bus.ex_taken_i),
        .wr_idx    (ex_bidx),
        .wr_tag    (ex_tag),
        .wr_target (bus.ex_target_i)
    );

    assign hit        = btb_valid && (btb_tag == if_tag);
    assign pred_taken = hit && pht[if_pidx][CTR_W-1];

    assign bus.pred_taken_o  = pred_taken;
    assign bus.pred_target_o = pred_taken ? btb_target : bus.if_pc_i + XLEN'(4);
    assign bus.pred_ghr_o    = ghr;

    assign train      = bus.ex_valid_i && bus.ex_is_branch_i;
    assign mispredict = train && ((bus.ex_taken_i != bus.ex_pred_taken_i) ||
                                  (bus.ex_taken_i && (bus.ex_target_i != bus.ex_pred_target_i)));

    assign bus.flush_o       = mispredict && !rst;
    assign bus.redirect_pc_o = !(mispredict && !rst) ? '0 :
                               bus.ex_taken_i ? bus.ex_target_i : bus.ex_pc_i + XLEN'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i] <= CTR_RST;
            end
        end else if (train) begin
            pht[ex_pidx] <= CTR_W'(ctr_next(32'(pht[ex_pidx]), bus.ex_taken_i, CTR_W));
        end
    end

    // Repair from EX outranks the speculative shift from IF.
    always_ff @(posedge clk) begin
        if (rst || (GSHARE != BPU_GSHARE)) begin
            ghr <= '0;
        end else if (mispredict) begin
            ghr <= ghr_push(bus.ex_ghr_i, bus.ex_taken_i);
        end else if (bus.if_valid_i && hit) begin
            ghr <= ghr_push(ghr, pred_taken);
        end
    end

endmodule

// File: doc/rv_bpu.md
# rv_bpu

Parametrised branch prediction unit for the 5-stage RV64 pipeline: a tagged branch target buffer (BTB) plus a pattern history table (PHT) of saturating counters, selectable bimodal or gshare indexing with a speculative global history register (GHR). Lookup is combinational in IF. Resolution from EX trains the tables, repairs the GHR and raises a flush with the redirect PC. It replaces the fixed 4-bit-address predictor in the core.

## Interface
- XLEN, 64, PC and target width
- ENTRIES, 16, BTB and PHT depth; power of two, ≥2; IW = log2(ENTRIES)
- TAG_W, 8, BTB tag width
- CTR_W, 2, PHT counter width, ≥1
- GSHARE, 0, 0 = bimodal, 1 = gshare
- GHR_W, 4, history length; 1 ≤ GHR_W ≤ IW
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_valid_i  in  1  IF lookup valid (low = stall/bubble)
- if_pc_i  in  XLEN  fetch PC
- pred_taken_o  out  1  predicted taken
- pred_target_o  out  XLEN  predicted next PC
- pred_ghr_o  out  GHR_W  GHR snapshot used for this lookup; pipelined to EX by the core
- ex_valid_i  in  1  EX resolution valid
- ex_is_branch_i  in  1  resolved instruction is a conditional branch or JAL
- ex_pc_i  in  XLEN  PC of resolved instruction
- ex_taken_i  in  1  actual direction
- ex_target_i  in  XLEN  actual taken target
- ex_pred_taken_i  in  1  prediction carried from IF
- ex_pred_target_i  in  XLEN  predicted target carried from IF
- ex_ghr_i  in  GHR_W  pred_ghr_o carried from IF
- flush_o  out  1  mispredict: squash IF/ID, ID/EX
- redirect_pc_o  out  XLEN  correct next PC when flush_o=1

## Operation
- Fields: bidx = pc[2 +: IW]; tag = pc[2+IW +: TAG_W]; pidx = bidx (bimodal) or bidx XOR zero-extended GHR (gshare).
- Lookup (combinational): hit = valid[bidx] && tag match. pred_taken_o = hit && pht[pidx][CTR_W-1]. pred_target_o = btb_target[bidx] if pred_taken_o, else if_pc_i+4 (modulo 2^XLEN).
- Mispredict = ex_valid_i && ex_is_branch_i && (ex_taken_i ≠ ex_pred_taken_i || (ex_taken_i && ex_target_i ≠ ex_pred_target_i)).
- On mispredict: flush_o=1. redirect_pc_o = ex_target_i if taken, else ex_pc_i+4. Otherwise flush_o=0 and redirect_pc_o=0.
- Training (on ex_valid_i && ex_is_branch_i):
  - PHT[pidx computed from ex_pc_i and ex_ghr_i] increments if taken, decrements if not; saturates at 2^CTR_W-1 and 0.
  - If taken: BTB[bidx] gets valid=1, tag, and target=ex_target_i.
  - Not-taken never invalidates a BTB entry.
- GHR, gshare only (held at 0 when GSHARE=0):
  - Mispredict: ghr ← {ex_ghr_i[GHR_W-2:0], ex_taken_i}.
  - Else if if_valid_i && hit: ghr ← {ghr[GHR_W-2:0], pred_taken_o}.
  - Else: hold.
  - For GHR_W=1, the shift reduces to the new bit only.
- Simultaneous events:
  - Lookup and training to the same entry in one cycle: lookup returns pre-update contents (read-before-write).
  - Mispredict repair has priority over speculative GHR shift.
- Non-branch resolutions (ex_is_branch_i=0) are ignored entirely.

## Timing
- Lookup: zero latency, combinational from if_pc_i and current state.
- flush_o / redirect_pc_o: combinational from EX inputs, same cycle.
- Table and GHR updates take effect at the next rising edge; visible to lookups one cycle after the training cycle.
- Reset (rst=1 at an edge):
  - All valid bits 0; all counters reset to weakly-not-taken, 2^(CTR_W-1)-1 (01 for CTR_W=2; 0 for CTR_W=1); GHR 0.
  - Targets and tags are don't-care.
  - flush_o forced 0 while rst=1.
  - After reset, every lookup yields pred_taken_o=0 and pred_target_o=if_pc_i+4.
  - Reset mid-operation discards pending training from that cycle.

## Structure
- rv_bpu_pkg: counter reset encoding, saturating next-counter function, index/tag extraction functions, mode constants BPU_BIMODAL/BPU_GSHARE.
- Sub-module rv_bpu_btb: valid/tag/target arrays with combinational read port and one synchronous write port. PHT and GHR stay in rv_bpu.

## Test plan
- Reset then lookup pc=0x100 → pred_taken_o=0, pred_target_o=0x104, flush_o=0.
- Train pc=0x100 taken→0x80 once (bimodal, CTR_W=2): same-cycle lookup still not-taken. Next-cycle lookup: ctr=10, pred_taken_o=1, target=0x80.
- Resolve pc=0x100 ex_pred_taken_i=1, ex_taken_i=0 → flush_o=1, redirect_pc_o=0x104. Counter saturates to 00 after 3 not-taken.
- Taken with ex_pred_target_i=0x80 but ex_target_i=0x90 → flush_o=1, redirect_pc_o=0x90; BTB target updated to 0x90.
- Gshare GHR_W=4: three hit-taken lookups give ghr=0111. Then a mispredict with ex_ghr_i=0001, ex_taken_i=0 the same cycle as a lookup hit → ghr=0010 (repair wins).
- Alias: pc=0x100 and 0x100+4·ENTRIES share bidx with different tags → second lookup misses; training it replaces the entry.
